// File: rtl/led_bank_scheduler.sv
// -----------------------------------------------------------------------------
// led_bank_scheduler
//
// Time-shares a 4-LED bank between NREQ requesters. A round-robin arbiter
// picks one pending requester, latches its 4-bit pattern and holds it on the
// LEDs for HOLD_TICKS prescaler ticks (DIVISOR clk_in cycles per tick). Then
// it returns to IDLE for at least one cycle before the next grant.
//
// Optional feature: define LED_SCHED_BLINK_EN to blink the granted pattern.
// The LEDs show the pattern and IDLE_PATTERN alternately, one tick each. The
// pattern phase comes first. busy and all timing stay the same.
//
// Ports:
//   clk_in   in   1         fabric clock, all state on its rising edge
//   rst      in   1         asynchronous, active-high reset
//   req      in   NREQ      level-sensitive request per requester
//   pattern  in   4*NREQ    pattern of requester i at bits [4i+3:4i]
//   ack      out  NREQ      one-cycle pulse to the granted requester
//   busy     out  1         high while a granted pattern is displayed
//   owner    out  log2 NREQ index of the current grantee, valid while busy
//   leds     out  4         registered LED drive
// -----------------------------------------------------------------------------
module led_bank_scheduler #(
    parameter int         NREQ         = 4,
    parameter int         DIVISOR      = 100000000,
    parameter int         HOLD_TICKS   = 3,
    parameter logic [3:0] IDLE_PATTERN = 4'b0000
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [4*NREQ-1:0]         pattern,
    output logic [NREQ-1:0]           ack,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic [3:0]                leds
);

    localparam int             OW        = $clog2(NREQ);
    localparam int             PW        = $clog2(DIVISOR);
    localparam logic [PW-1:0]  PS_LAST   = PW'(DIVISOR - 1);
    localparam logic [7:0]     TICK_LAST = 8'(HOLD_TICKS - 1);
    localparam logic [OW-1:0]  IDX_LAST  = OW'(NREQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [OW-1:0]   rr_ptr;
    logic [3:0]      latched;
    logic [PW-1:0]   prescaler;
    logic [7:0]      tick_cnt;

    logic [OW-1:0]   winner;
    logic [3:0]      win_pattern;
    logic [OW-1:0]   scan_ix;
    int              scan_sum;

    logic            grant;
    logic            tick;
    logic            last_tick;
    logic [3:0]      shown;

    logic [NREQ-1:0] ack_d;
    logic            busy_d;
    logic [3:0]      leds_d;

`ifdef LED_SCHED_BLINK_EN
    logic            phase;
    logic            phase_d;
`endif

    // ------------------------------------------------------------------
    // Round-robin winner. The scan runs from the highest offset down to the
    // lowest, so the last hit is the first set bit at or above rr_ptr,
    // with wrap.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // block leaves it unassigned. That keeps it combinational rather
        // than an inferred latch.
        winner      = '0;
        scan_ix     = '0;
        scan_sum    = 0;
        win_pattern = IDLE_PATTERN;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_sum = int'(rr_ptr) + k;
            if (scan_sum >= NREQ) begin
                scan_sum = scan_sum - NREQ;
            end
            scan_ix = OW'(scan_sum);
            if (req[scan_ix]) begin
                winner = scan_ix;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (winner == OW'(i)) begin
                win_pattern = pattern[4*i +: 4];
            end
        end
    end

    assign grant     = (state_q == IDLE) && (|req);
    assign tick      = (prescaler == PS_LAST);
    assign last_tick = tick && (tick_cnt == TICK_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together at the edge, whatever order the
    // processes are evaluated in.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (|req)     state_d = SHOW;
            SHOW: if (last_tick) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. These are the next values of the registered outputs,
    // so the outputs change on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        ack_d  = grant ? (NREQ'(1) << winner) : '0;
        busy_d = (state_d == SHOW);
        shown  = grant ? win_pattern : latched;
`ifdef LED_SCHED_BLINK_EN
        phase_d = phase;
        if (grant) begin
            phase_d = 1'b1;
        end else if ((state_q == SHOW) && tick) begin
            phase_d = ~phase;
        end
        leds_d = ((state_d == SHOW) && phase_d) ? shown : IDLE_PATTERN;
`else
        leds_d = (state_d == SHOW) ? shown : IDLE_PATTERN;
`endif
    end

    // ------------------------------------------------------------------
    // Datapath and output registers. Reset clears everything, so nothing
    // latched before a mid-SHOW reset survives it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            ack       <= '0;
            busy      <= 1'b0;
            owner     <= '0;
            leds      <= IDLE_PATTERN;
            rr_ptr    <= '0;
            latched   <= '0;
            prescaler <= '0;
            tick_cnt  <= '0;
`ifdef LED_SCHED_BLINK_EN
            phase     <= 1'b0;
`endif
        end else begin
            ack  <= ack_d;
            busy <= busy_d;
            leds <= leds_d;
`ifdef LED_SCHED_BLINK_EN
            phase <= phase_d;
`endif
            if (grant) begin
                owner     <= winner;
                latched   <= win_pattern;
                rr_ptr    <= (winner == IDX_LAST) ? '0 : winner + OW'(1);
                prescaler <= '0;
                tick_cnt  <= '0;
            end else if (state_q == SHOW) begin
                if (tick) begin
                    prescaler <= '0;
                    tick_cnt  <= tick_cnt + 8'd1;
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end
        end
    end

endmodule
